// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - field-bundle stream and IM write port bundle
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [25:0]       in_imm;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes MIPS field bundles and streams the words into IM
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    instr_encoder_loader_if.slave     bus,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              in_ready_c;
    logic              accept;
    logic              wr_done;

    // Fields not used by a mnemonic are forced to zero so stray bundle bits never leak into the word.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [25:0] imm
    );
        logic [15:0] i16;
        logic [31:0] w;
        i16 = imm[15:0];
        case (op)
            4'd0:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            4'd1:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            4'd2:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};
            4'd3:    w = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            4'd4:    w = {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
            4'd5:    w = {6'b000000, 5'd0, rt, rd, sh, 6'b000000};
            4'd6:    w = {6'b001101, rs, rt, i16};
            4'd7:    w = {6'b100011, rs, rt, i16};
            4'd8:    w = {6'b101011, rs, rt, i16};
            4'd9:    w = {6'b000100, rs, rt, i16};
            4'd10:   w = {6'b001111, 5'd0, rt, i16};
            4'd11:   w = {6'b000011, imm};
            4'd12:   w = {6'b000010, imm};
            4'd13:   w = {6'b100000, rs, rt, i16};
            4'd14:   w = {6'b000111, rs, 5'd0, i16};
            default: w = {6'b110111, rs, rt, i16};
        endcase
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        im_we_d    = im_we_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        in_ready_c = (state_q == LOAD) && (!im_we_q || bus.im_ready);
        accept     = bus.in_valid && in_ready_c;
        wr_done    = im_we_q && bus.im_ready;

        if (wr_done) begin
            im_we_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end

        // ptr always holds the address the next accepted word will take.
        if (accept) begin
            im_we_d    = 1'b1;
            im_addr_d  = ptr_q;
            im_wdata_d = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_imm);
            ptr_d      = ptr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = base_addr;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept && bus.in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign count        = count_q;
endmodule
